// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment decode/scan path.
package seven_seg_pkg;

  // One digit's segment pattern, bit0 = a ... bit6 = g, active-high.
  typedef logic [6:0] seven_seg_t;

  // Centre bar only: shown before any real pattern has been loaded.
  localparam seven_seg_t DASH    = 7'h40;
  // Every segment dark, active-high.
  localparam seven_seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Pattern-load and display-pin bundle for seven_seg_scan.
interface seven_seg_scan_if
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_COUNT = 2
);

  seven_seg_t [DIGIT_COUNT-1:0] seg_in;
  logic                         load;
  seven_seg_t                   seg_out;
  logic [DIGIT_COUNT-1:0]       dig_en;
  logic                         frame_start;
  logic                         update_pending;

  modport master (
    output seg_in, load,
    input  seg_out, dig_en, frame_start, update_pending
  );

  modport slave (
    input  seg_in, load,
    output seg_out, dig_en, frame_start, update_pending
  );

endinterface

// File: rtl/seven_seg_refresh_timer.sv
// Slot and digit counters for the display scan. The counters hold the
// position of the cycle that begins at the next clock edge, so the scan
// top can register its outputs from them and still have registered pins
// that describe the current cycle.
module seven_seg_refresh_timer #(
  parameter int DIGIT_COUNT  = 2,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             blank,
  output logic [IDX_W-1:0] digit_idx,
  output logic             frame_start
);

  localparam int              SLOT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGIT_COUNT - 1);

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;

  // Advance the slot counter; step the digit at slot end, wrapping per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign digit_idx   = idx;
  assign blank       = (BLANK_CYCLES > 0) && (int'(slot_cnt) < BLANK_CYCLES);
  assign frame_start = (slot_cnt == '0) && (idx == '0);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: double-buffered patterns that
// switch only at frame boundaries, a leading blank per digit slot, and
// optional pin inversion.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_COUNT    = 2,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seven_seg_scan_if.slave  bus
);

  localparam int IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  typedef seven_seg_t [DIGIT_COUNT-1:0] seg_array_t;

  seg_array_t             staging;
  seg_array_t             shadow;
  seg_array_t             shadow_nxt;
  logic                   pending;
  logic                   blank;
  logic                   boundary;
  logic [IDX_W-1:0]       idx;
  logic [DIGIT_COUNT-1:0] dig_q;
  seven_seg_t             seg_q;
  logic                   fs_q;

  // boundary is high during the last cycle of a frame (and while held in
  // reset), i.e. the coming edge enters cycle 0 of a frame.
  seven_seg_refresh_timer #(
    .DIGIT_COUNT  (DIGIT_COUNT),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .blank       (blank),
    .digit_idx   (idx),
    .frame_start (boundary)
  );

  // Pattern set for the coming cycle: a load on the boundary edge bypasses staging.
  always_comb begin
    shadow_nxt = shadow;
    if (boundary) begin
      if (bus.load) begin
        shadow_nxt = bus.seg_in;
      end else if (pending) begin
        shadow_nxt = staging;
      end
    end
  end

  // Double buffer: capture loads into staging, commit to shadow on frame boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      staging <= {DIGIT_COUNT{DASH}};
      shadow  <= {DIGIT_COUNT{DASH}};
      pending <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (boundary) begin
        pending <= 1'b0;
      end else if (bus.load) begin
        staging <= bus.seg_in;
        pending <= 1'b1;
      end
    end
  end

  // Registered digit enable and segment bus; dig_en and seg_out move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q <= '0;
      seg_q <= SEG_OFF;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= boundary;
      if (blank) begin
        dig_q <= '0;
        seg_q <= SEG_OFF;
      end else begin
        dig_q <= DIGIT_COUNT'(1) << idx;
        seg_q <= shadow_nxt[idx];
      end
    end
  end

  assign bus.seg_out        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign bus.dig_en         = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
  assign bus.frame_start    = fs_q;
  assign bus.update_pending = pending;

endmodule
